jtag_tap_target: RTL and testbench

Parametrised JTAG target-side Test Access Port: full 16-state TAP controller, instruction register of configurable width and a test-vector data register of configurable width, plus a 1-bit bypass register. It is the DUT-side counterpart the AVIP drives. It generalises the fixed width enums (instruction 3/4/5 bits, vector 8/16/24/32 bits) into parameters and adds real capture/shift/update behaviour. `clk` is TCK; `tms` and `tdi` are sampled on its rising edge.

---
 rtl/jtag_tap_target_pkg.sv | 58 +++++
 rtl/jtag_tap_fsm.sv | 62 ++++++
 rtl/jtag_tap_target.sv | 126 ++++++++++++
 tb/tb_jtag_tap_target.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/jtag_tap_target_pkg.sv
// Shared types and constants for the JTAG target TAP.
// The IDCODE register and opcode are present only when JTAG_IDCODE_EN is defined.
package jtag_tap_target_pkg;

    // IEEE 1149.1 TAP states, with the customary 4-bit encoding (TLR = 4'hF)
    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'hF,
        RUN_TEST_IDLE    = 4'hC,
        SELECT_DR        = 4'h7,
        CAPTURE_DR       = 4'h6,
        SHIFT_DR         = 4'h2,
        EXIT1_DR         = 4'h1,
        PAUSE_DR         = 4'h3,
        EXIT2_DR         = 4'h0,
        UPDATE_DR        = 4'h5,
        SELECT_IR        = 4'h4,
        CAPTURE_IR       = 4'hE,
        SHIFT_IR         = 4'hA,
        EXIT1_IR         = 4'h9,
        PAUSE_IR         = 4'hB,
        EXIT2_IR         = 4'h8,
        UPDATE_IR        = 4'hD
    } tap_state_t;

    typedef enum logic [1:0] {
        SEL_BYPASS,
        SEL_TESTVEC,
        SEL_IDCODE
    } dr_sel_t;

    localparam int unsigned OP_BYPASS  = 0;
    localparam int unsigned OP_TESTVEC = 1;
    localparam int unsigned OP_IDCODE  = 2;

    localparam int IDCODE_WIDTH    = 32;
    localparam int INSTR_WIDTH_MIN = 3;
    localparam int INSTR_WIDTH_MAX = 5;
    localparam int TV_WIDTH_STEP   = 8;
    localparam int TV_WIDTH_MAX    = 32;

    function automatic bit legal_instr_width(input int w);
        return (w >= INSTR_WIDTH_MIN) && (w <= INSTR_WIDTH_MAX);
    endfunction

    function automatic bit legal_tv_width(input int w);
        return (w >= TV_WIDTH_STEP) && (w <= TV_WIDTH_MAX) && ((w % TV_WIDTH_STEP) == 0);
    endfunction

    // Any opcode without a dedicated register falls back to bypass
    function automatic dr_sel_t decode_ir(input logic [31:0] op);
        if (op == OP_TESTVEC) return SEL_TESTVEC;
`ifdef JTAG_IDCODE_EN
        if (op == OP_IDCODE) return SEL_IDCODE;
`endif
        return SEL_BYPASS;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// TAP controller: 16-state state register, tms-driven next-state logic and
// one-hot decodes of the capture/shift/update states for IR and DR.
module jtag_tap_fsm
    import jtag_tap_target_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tms,
    output tap_state_t state,
    output logic       capture_ir,
    output logic       shift_ir,
    output logic       update_ir,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr,
    output logic       reset_next
);

    tap_state_t next_state;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) state <= TEST_LOGIC_RESET;
        else        state <= next_state;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            TEST_LOGIC_RESET: next_state = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    next_state = tms ? SELECT_DR : RUN_TEST_IDLE;
            SELECT_DR:        next_state = tms ? SELECT_IR : CAPTURE_DR;
            CAPTURE_DR:       next_state = tms ? EXIT1_DR  : SHIFT_DR;
            SHIFT_DR:         next_state = tms ? EXIT1_DR  : SHIFT_DR;
            EXIT1_DR:         next_state = tms ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:         next_state = tms ? EXIT2_DR  : PAUSE_DR;
            EXIT2_DR:         next_state = tms ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:        next_state = tms ? SELECT_DR : RUN_TEST_IDLE;
            SELECT_IR:        next_state = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       next_state = tms ? EXIT1_IR  : SHIFT_IR;
            SHIFT_IR:         next_state = tms ? EXIT1_IR  : SHIFT_IR;
            EXIT1_IR:         next_state = tms ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:         next_state = tms ? EXIT2_IR  : PAUSE_IR;
            EXIT2_IR:         next_state = tms ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:        next_state = tms ? SELECT_DR : RUN_TEST_IDLE;
            default:          next_state = TEST_LOGIC_RESET;
        endcase
    end

    always_comb begin
        capture_ir = (state == CAPTURE_IR);
        shift_ir   = (state == SHIFT_IR);
        update_ir  = (state == UPDATE_IR);
        capture_dr = (state == CAPTURE_DR);
        shift_dr   = (state == SHIFT_DR);
        update_dr  = (state == UPDATE_DR);
        // Lets the instruction be reset on the same edge that enters Test-Logic-Reset
        reset_next = (next_state == TEST_LOGIC_RESET);
    end

endmodule

// File: rtl/jtag_tap_target.sv
// JTAG target TAP: instruction register, bypass and test-vector data registers,
// plus an IDCODE register when JTAG_IDCODE_EN is defined.
module jtag_tap_target
    import jtag_tap_target_pkg::*;
#(
    parameter int          INSTR_WIDTH  = 5,
    parameter int          TV_WIDTH     = 32,
    parameter logic [31:0] IDCODE_VALUE = 32'h1234_5A5F
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tms,
    input  logic                   tdi,
    output logic                   tdo,
    output logic                   tdoEn,
    input  logic [TV_WIDTH-1:0]    captureVector,
    output logic [TV_WIDTH-1:0]    updateVector,
    output logic                   updateStrobe,
    output logic [INSTR_WIDTH-1:0] irValue,
    output logic [3:0]             tapState
);

    if (!legal_instr_width(INSTR_WIDTH) || !legal_tv_width(TV_WIDTH) || !IDCODE_VALUE[0]) begin : g_bad_params
        $error("jtag_tap_target: illegal INSTR_WIDTH, TV_WIDTH or IDCODE_VALUE");
    end

`ifdef JTAG_IDCODE_EN
    localparam logic [INSTR_WIDTH-1:0] RESET_IR = INSTR_WIDTH'(OP_IDCODE);
`else
    localparam logic [INSTR_WIDTH-1:0] RESET_IR = INSTR_WIDTH'(OP_BYPASS);
`endif

    tap_state_t state;
    logic       capture_ir, shift_ir, update_ir;
    logic       capture_dr, shift_dr, update_dr;
    logic       reset_next;

    jtag_tap_fsm u_fsm (
        .clk        (clk),
        .reset      (reset),
        .tms        (tms),
        .state      (state),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .update_ir  (update_ir),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .reset_next (reset_next)
    );

    logic [INSTR_WIDTH-1:0]  ir_sr;
    logic [TV_WIDTH-1:0]     tv_sr;
    logic                    bypass_sr;
    dr_sel_t                 dr_sel;
`ifdef JTAG_IDCODE_EN
    logic [IDCODE_WIDTH-1:0] idcode_sr;
`endif

    assign dr_sel = decode_ir(32'(irValue));

    always_ff @(posedge clk) begin
        if (!reset) begin
            ir_sr        <= '0;
            irValue      <= RESET_IR;
            tv_sr        <= '0;
            bypass_sr    <= 1'b0;
            updateVector <= '0;
            updateStrobe <= 1'b0;
`ifdef JTAG_IDCODE_EN
            idcode_sr    <= '0;
`endif
        end else begin
            updateStrobe <= 1'b0;

            if (capture_ir)    ir_sr <= INSTR_WIDTH'(2'b01);
            else if (shift_ir) ir_sr <= {tdi, ir_sr[INSTR_WIDTH-1:1]};

            if (update_ir)       irValue <= ir_sr;
            else if (reset_next) irValue <= RESET_IR;

            // Only the register selected by the current instruction captures or shifts
            if (capture_dr) begin
                unique case (dr_sel)
                    SEL_TESTVEC: tv_sr     <= captureVector;
`ifdef JTAG_IDCODE_EN
                    SEL_IDCODE:  idcode_sr <= IDCODE_VALUE;
`endif
                    default:     bypass_sr <= 1'b0;
                endcase
            end else if (shift_dr) begin
                unique case (dr_sel)
                    SEL_TESTVEC: tv_sr     <= {tdi, tv_sr[TV_WIDTH-1:1]};
`ifdef JTAG_IDCODE_EN
                    SEL_IDCODE:  idcode_sr <= {tdi, idcode_sr[IDCODE_WIDTH-1:1]};
`endif
                    default:     bypass_sr <= tdi;
                endcase
            end

            if (update_dr && dr_sel == SEL_TESTVEC) begin
                updateVector <= tv_sr;
                updateStrobe <= 1'b1;
            end
        end
    end

    always_comb begin
        tdo = 1'b0;
        if (shift_ir) begin
            tdo = ir_sr[0];
        end else if (shift_dr) begin
            unique case (dr_sel)
                SEL_TESTVEC: tdo = tv_sr[0];
`ifdef JTAG_IDCODE_EN
                SEL_IDCODE:  tdo = idcode_sr[0];
`endif
                default:     tdo = bypass_sr;
            endcase
        end
    end

    assign tdoEn    = shift_ir | shift_dr;
    assign tapState = state;

endmodule

// File: tb/tb_jtag_tap_target.sv
// Directed bench for jtag_tap_target (INSTR_WIDTH=5, TV_WIDTH=8); expectations
// follow JTAG_IDCODE_EN so the same bench serves both builds.
module tb_jtag_tap_target;

    localparam int          IW     = 5;
    localparam int          TW     = 8;
    localparam logic [31:0] IDCODE = 32'h1234_5A5F;
`ifdef JTAG_IDCODE_EN
    localparam logic [IW-1:0] RESET_IR = 5'd2;
`else
    localparam logic [IW-1:0] RESET_IR = 5'd0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          tms = 1'b1;
    logic          tdi = 1'b0;
    logic          tdo, tdo_en, update_strobe;
    logic [TW-1:0] capture_vector = '0;
    logic [TW-1:0] update_vector;
    logic [IW-1:0] ir_value;
    logic [3:0]    tap_state;

    int n_cmp = 0;
    int n_bad = 0;

    jtag_tap_target #(.INSTR_WIDTH(IW), .TV_WIDTH(TW), .IDCODE_VALUE(IDCODE)) dut (
        .clk           (clk),
        .reset         (reset),
        .tms           (tms),
        .tdi           (tdi),
        .tdo           (tdo),
        .tdoEn         (tdo_en),
        .captureVector (capture_vector),
        .updateVector  (update_vector),
        .updateStrobe  (update_strobe),
        .irValue       (ir_value),
        .tapState      (tap_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive tms/tdi, take one rising edge, then settle 1 time unit past it
    task automatic tick(input logic t, input logic d);
        tms = t;
        tdi = d;
        @(posedge clk);
        #1;
    endtask

    // From Run-Test/Idle: scan an instruction LSB-first and return to Run-Test/Idle
    task automatic scan_ir(input logic [IW-1:0] val, output logic [IW-1:0] seen);
        tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        for (int i = 0; i < IW; i++) begin
            seen[i] = tdo;
            tick(i == IW - 1, val[i]);
        end
        tick(1, 0);
        tick(0, 0);
    endtask

    // From Run-Test/Idle: shift n bits LSB-first, stopping in Update-DR
    task automatic scan_dr(input logic [31:0] val, input int n, output logic [31:0] seen);
        seen = '0;
        tick(1, 0); tick(0, 0); tick(0, 0);
        for (int i = 0; i < n; i++) begin
            seen[i] = tdo;
            tick(i == n - 1, val[i]);
        end
        tick(1, 0);
    endtask

    typedef struct {
        logic       tms;
        logic [3:0] exp_state;
        logic       exp_tdo_en;
    } walk_t;

    walk_t walk[24];

    initial begin
        logic [IW-1:0] ir_seen;
        logic [31:0]   dr_seen;

        walk[0]  = '{1'b0, 4'hC, 1'b0};  walk[1]  = '{1'b1, 4'h7, 1'b0};
        walk[2]  = '{1'b0, 4'h6, 1'b0};  walk[3]  = '{1'b0, 4'h2, 1'b1};
        walk[4]  = '{1'b1, 4'h1, 1'b0};  walk[5]  = '{1'b0, 4'h3, 1'b0};
        walk[6]  = '{1'b1, 4'h0, 1'b0};  walk[7]  = '{1'b0, 4'h2, 1'b1};
        walk[8]  = '{1'b1, 4'h1, 1'b0};  walk[9]  = '{1'b1, 4'h5, 1'b0};
        walk[10] = '{1'b1, 4'h7, 1'b0};  walk[11] = '{1'b1, 4'h4, 1'b0};
        walk[12] = '{1'b0, 4'hE, 1'b0};  walk[13] = '{1'b0, 4'hA, 1'b1};
        walk[14] = '{1'b1, 4'h9, 1'b0};  walk[15] = '{1'b0, 4'hB, 1'b0};
        walk[16] = '{1'b0, 4'hB, 1'b0};  walk[17] = '{1'b1, 4'h8, 1'b0};
        walk[18] = '{1'b1, 4'hD, 1'b0};  walk[19] = '{1'b0, 4'hC, 1'b0};
        walk[20] = '{1'b1, 4'h7, 1'b0};  walk[21] = '{1'b1, 4'h4, 1'b0};
        walk[22] = '{1'b1, 4'hF, 1'b0};  walk[23] = '{1'b1, 4'hF, 1'b0};

        // Reset held for two clocks
        reset = 1'b0;
        tick(1, 0); tick(1, 0);
        check("reset tapState", 32'(tap_state), 32'hF);
        check("reset irValue", 32'(ir_value), 32'(RESET_IR));
        check("reset tdoEn", 32'(tdo_en), 0);
        check("reset tdo", 32'(tdo), 0);
        check("reset updateVector", 32'(update_vector), 0);
        check("reset updateStrobe", 32'(update_strobe), 0);
        reset = 1'b1;

        // Walk every TAP state
        for (int i = 0; i < 24; i++) begin
            tick(walk[i].tms, 1'b0);
            check($sformatf("walk[%0d] tapState", i), 32'(tap_state), 32'(walk[i].exp_state));
            check($sformatf("walk[%0d] tdoEn", i), 32'(tdo_en), 32'(walk[i].exp_tdo_en));
            check($sformatf("walk[%0d] updateStrobe", i), 32'(update_strobe), 0);
        end
        check("walk end irValue", 32'(ir_value), 32'(RESET_IR));
        tick(0, 0);

        // IR scan: captured 00001 comes out first, new instruction TESTVEC
        scan_ir(5'b00001, ir_seen);
        check("ir capture tdo", 32'(ir_seen), 32'h01);
        check("ir update TESTVEC", 32'(ir_value), 32'h01);

        // TESTVEC: capture A5, shift in 3C
        capture_vector = 8'hA5;
        scan_dr(32'h3C, TW, dr_seen);
        check("tv capture tdo", dr_seen, 32'hA5);
        check("tv strobe before update edge", 32'(update_strobe), 0);
        tick(0, 0);
        check("tv updateStrobe", 32'(update_strobe), 1);
        check("tv updateVector", 32'(update_vector), 32'h3C);
        tick(0, 0);
        check("tv strobe one cycle", 32'(update_strobe), 0);
        check("tv updateVector held", 32'(update_vector), 32'h3C);

        // BYPASS: tdi 1,0,1,1 returns 0,1,0,1
        scan_ir(5'b00000, ir_seen);
        check("ir capture tdo 2", 32'(ir_seen), 32'h01);
        check("ir update BYPASS", 32'(ir_value), 0);
        scan_dr(32'b1101, 4, dr_seen);
        check("bypass tdo", dr_seen, 32'b1010);
        tick(0, 0);
        check("bypass no strobe", 32'(update_strobe), 0);
        check("bypass updateVector held", 32'(update_vector), 32'h3C);

        // Unassigned opcode, then five tms=1 from Shift-DR
        scan_ir(5'd3, ir_seen);
        check("ir update opcode 3", 32'(ir_value), 3);
        tick(1, 0); tick(0, 0); tick(0, 0);
        check("enter Shift-DR", 32'(tap_state), 32'h2);
        for (int i = 0; i < 5; i++) begin
            tick(1, 1);
            check($sformatf("tms reset step %0d strobe", i), 32'(update_strobe), 0);
        end
        check("tms reset tapState", 32'(tap_state), 32'hF);
        check("tms reset irValue", 32'(ir_value), 32'(RESET_IR));
        check("tms reset updateVector held", 32'(update_vector), 32'h3C);
        tick(0, 0);

        // Opcode 2: IDCODE when enabled, otherwise bypass
        scan_ir(5'd2, ir_seen);
        check("ir update opcode 2", 32'(ir_value), 2);
`ifdef JTAG_IDCODE_EN
        scan_dr(32'h0, 32, dr_seen);
        check("idcode tdo", dr_seen, IDCODE);
`else
        scan_dr(32'b1111, 4, dr_seen);
        check("opcode 2 bypass tdo", dr_seen, 32'b1110);
`endif
        tick(0, 0);
        check("opcode 2 no strobe", 32'(update_strobe), 0);

        // Reset mid-scan aborts at the next edge
        tick(1, 0); tick(0, 0); tick(0, 0);
        tick(0, 1); tick(0, 1);
        check("mid-scan tdoEn", 32'(tdo_en), 1);
        reset = 1'b0;
        tick(0, 1);
        check("mid-scan reset tapState", 32'(tap_state), 32'hF);
        check("mid-scan reset tdoEn", 32'(tdo_en), 0);
        check("mid-scan reset strobe", 32'(update_strobe), 0);
        check("mid-scan reset updateVector", 32'(update_vector), 0);
        check("mid-scan reset irValue", 32'(ir_value), 32'(RESET_IR));
        reset = 1'b1;
        tick(1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
